mem_port_arbiter: RTL and testbench

Arbitrates one single-ported memory slave between the instruction-fetch bus (read-only) and the data bus (read/write). Uses fair round-robin with a lock held for the whole transaction. Routes the response and the done strobe back to the owning requester only. Aborts a stalled transaction after a programmable timeout with an error pulse. Sits between the core's two bus masters and a single-port memory or peripheral slave.

---
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port slave between the ibus (read-only)
// and the dbus. The owner holds the slave for a whole transaction, and a stalled
// transaction is aborted with an error pulse after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_bdone,
  output logic          i_berr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [1:0]    d_tsize,
  output logic [DW-1:0] d_rdata,
  output logic          d_bdone,
  output logic          d_berr,
  output logic          s_req,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic [1:0]    s_tsize,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_bdone
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_e;

  state_e        state_q, state_d;
  logic          last_d_q, last_d_d;   // 1: dbus was the last owner
  logic [CW-1:0] cnt_q, cnt_d;
  logic          own_i, own_d, owned, tmo, fin;

  assign own_i = (state_q == OWN_I);
  assign own_d = (state_q == OWN_D);
  assign owned = own_i | own_d;
  // A slave done in the final cycle wins over the abort.
  assign tmo   = owned && (cnt_q == CW'(TIMEOUT - 1)) && !s_bdone;
  assign fin   = owned && (s_bdone || tmo);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE: begin
        if (i_req && (!d_req || last_d_q)) state_d = OWN_I;
        else if (d_req)                    state_d = OWN_D;
      end
      OWN_I: begin
        if (fin) begin
          last_d_d = 1'b0;
          state_d  = d_req ? OWN_D : IDLE;
        end
      end
      OWN_D: begin
        if (fin) begin
          last_d_d = 1'b1;
          state_d  = i_req ? OWN_I : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Every OWN entry comes from IDLE or a finishing cycle, so both clear.
    if (!owned || fin) cnt_d = '0;
    else               cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    s_req   = owned;
    s_we    = own_d & d_we;
    s_addr  = own_i ? i_addr : (own_d ? d_addr : '0);
    s_wdata = own_d ? d_wdata : '0;
    s_tsize = own_i ? 2'b10 : (own_d ? d_tsize : 2'b00);
    i_bdone = own_i & fin;
    i_berr  = own_i & tmo;
    i_rdata = (own_i && s_bdone) ? s_rdata : '0;
    d_bdone = own_d & fin;
    d_berr  = own_d & tmo;
    d_rdata = (own_d && s_bdone) ? s_rdata : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are checked
// just after each falling edge, so the rising edge always sees settled inputs.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, TIMEOUT = 16;

  logic          clk = 1'b0, rst = 1'b0;
  logic          i_req = 0, d_req = 0, d_we = 0, s_bdone = 0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, s_rdata = '0;
  logic [1:0]    d_tsize = '0;
  logic [DW-1:0] i_rdata, d_rdata, s_wdata;
  logic [AW-1:0] s_addr;
  logic          i_bdone, i_berr, d_bdone, d_berr, s_req, s_we;
  logic [1:0]    s_tsize;
  int errors = 0, checks = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_bdone(i_bdone), .i_berr(i_berr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_tsize(d_tsize),
    .d_rdata(d_rdata), .d_bdone(d_bdone), .d_berr(d_berr),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_tsize(s_tsize),
    .s_rdata(s_rdata), .s_bdone(s_bdone)
  );

  always #5 clk = ~clk;

  // Requester contract: address held while a request waits for its done.
  a_i_stable: assert property (@(posedge clk) disable iff (rst)
    (i_req && $past(i_req) && !$past(i_bdone)) |-> $stable(i_addr));
  a_d_stable: assert property (@(posedge clk) disable iff (rst)
    (d_req && $past(d_req) && !$past(d_bdone)) |-> ($stable(d_addr) && $stable(d_we)));

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; s_bdone = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_tsize = '0; s_rdata = '0;
    nxt(); nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++;
    if ({s_req, s_we, i_bdone, d_bdone, i_berr, d_berr} !== 6'b0 || s_addr !== '0 ||
        i_rdata !== '0 || d_rdata !== '0 || s_tsize !== 2'b00) begin
      errors++; $display("FAIL reset_outputs: s_req=%b s_addr=%h i_rdata=%h expected all 0",
                         s_req, s_addr, i_rdata);
    end
    // Stray slave done while idle must not produce any pulse.
    s_bdone = 1; settle();
    checks++;
    if (i_bdone !== 0 || d_bdone !== 0 || s_req !== 0) begin
      errors++; $display("FAIL idle_bdone: i_bdone=%b d_bdone=%b s_req=%b expected 0", i_bdone, d_bdone, s_req);
    end
    nxt(); s_bdone = 0;
  endtask

  task automatic test_ibus_read();
    do_reset();
    i_req = 1; i_addr = 32'h40; settle();
    checks++;
    if (s_req !== 0) begin errors++; $display("FAIL i_grant_latency: s_req=%b expected 0", s_req); end
    nxt();
    s_bdone = 1; s_rdata = 32'hDEADBEEF; settle();
    checks++;
    if (s_req !== 1 || s_we !== 0 || s_tsize !== 2'b10 || s_addr !== 32'h40) begin
      errors++; $display("FAIL i_slave_drive: req=%b we=%b tsize=%b addr=%h expected 1 0 10 00000040",
                         s_req, s_we, s_tsize, s_addr);
    end
    checks++;
    if (i_bdone !== 1 || i_berr !== 0 || i_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL i_done: bdone=%b berr=%b rdata=%h expected 1 0 deadbeef", i_bdone, i_berr, i_rdata);
    end
    checks++;
    if (d_bdone !== 0 || d_berr !== 0 || d_rdata !== '0) begin
      errors++; $display("FAIL i_dquiet: d_bdone=%b d_berr=%b d_rdata=%h expected 0", d_bdone, d_berr, d_rdata);
    end
    nxt(); i_req = 0; s_bdone = 0; settle();
    checks++;
    if (s_req !== 0 || i_bdone !== 0) begin
      errors++; $display("FAIL i_back_idle: s_req=%b i_bdone=%b expected 0 0", s_req, i_bdone);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_req = 1; i_addr = 32'h1000; d_req = 1; d_addr = 32'h2000; d_we = 0;
    nxt();
    for (int r = 0; r < 4; r++) begin
      // First ibus cycle of the round.
      if (r > 0) d_req = 0;
      s_bdone = 0; settle();
      checks++;
      if (s_req !== 1 || s_addr !== 32'h1000 + 32'(r) || s_tsize !== 2'b10) begin
        errors++; $display("FAIL rr_i_own r%0d: s_req=%b s_addr=%h expected 1 %h", r, s_req, s_addr, 32'h1000 + 32'(r));
      end
      nxt();
      if (r > 0) begin d_req = 1; d_addr = 32'h2000 + 32'(r); end
      s_bdone = 1; s_rdata = 32'hA000_0000 + 32'(r); settle();
      checks++;
      if (i_bdone !== 1 || i_rdata !== 32'hA000_0000 + 32'(r) || d_bdone !== 0) begin
        errors++; $display("FAIL rr_i_done r%0d: i_bdone=%b i_rdata=%h d_bdone=%b expected 1 %h 0",
                           r, i_bdone, i_rdata, d_bdone, 32'hA000_0000 + 32'(r));
      end
      nxt();
      i_req = 0; s_bdone = 0; settle();
      checks++;
      if (s_req !== 1 || s_addr !== 32'h2000 + 32'(r)) begin
        errors++; $display("FAIL rr_d_handoff r%0d: s_req=%b s_addr=%h expected 1 %h", r, s_req, s_addr, 32'h2000 + 32'(r));
      end
      nxt();
      i_req = 1; i_addr = 32'h1000 + 32'(r + 1);
      s_bdone = 1; s_rdata = 32'hB000_0000 + 32'(r); settle();
      checks++;
      if (d_bdone !== 1 || d_rdata !== 32'hB000_0000 + 32'(r) || i_bdone !== 0 || i_rdata !== '0) begin
        errors++; $display("FAIL rr_d_done r%0d: d_bdone=%b d_rdata=%h i_bdone=%b expected 1 %h 0",
                           r, d_bdone, d_rdata, i_bdone, 32'hB000_0000 + 32'(r));
      end
      nxt();
    end
    i_req = 0; d_req = 0; s_bdone = 0;
  endtask

  task automatic test_dbus_write();
    do_reset();
    d_req = 1; d_we = 1; d_addr = 32'h103; d_wdata = 32'hA5; d_tsize = 2'b00;
    nxt(); settle();
    checks++;
    if (s_req !== 1 || s_we !== 1 || s_addr !== 32'h103 || s_wdata !== 32'hA5 || s_tsize !== 2'b00) begin
      errors++; $display("FAIL d_write_drive: req=%b we=%b addr=%h wdata=%h tsize=%b expected 1 1 103 a5 00",
                         s_req, s_we, s_addr, s_wdata, s_tsize);
    end
    nxt(); s_bdone = 1; settle();
    checks++;
    if (d_bdone !== 1 || d_berr !== 0 || i_bdone !== 0) begin
      errors++; $display("FAIL d_write_done: d_bdone=%b d_berr=%b i_bdone=%b expected 1 0 0", d_bdone, d_berr, i_bdone);
    end
    nxt(); d_req = 0; d_we = 0; s_bdone = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h300; s_rdata = 32'h12345678;
    nxt();
    // OWN cycle k runs with counter value k; the abort lands in cycle TIMEOUT-1.
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      settle();
      checks++;
      if (s_req !== 1 || d_bdone !== 0) begin
        errors++; $display("FAIL tmo_wait k%0d: s_req=%b d_bdone=%b expected 1 0", k, s_req, d_bdone);
      end
      nxt();
    end
    settle();
    checks++;
    if (d_bdone !== 1 || d_berr !== 1 || d_rdata !== '0 || s_req !== 1) begin
      errors++; $display("FAIL tmo_fire: d_bdone=%b d_berr=%b d_rdata=%h s_req=%b expected 1 1 0 1",
                         d_bdone, d_berr, d_rdata, s_req);
    end
    nxt(); d_req = 0; settle();
    checks++;
    if (s_req !== 0 || d_berr !== 0) begin
      errors++; $display("FAIL tmo_idle: s_req=%b d_berr=%b expected 0 0", s_req, d_berr);
    end
    i_req = 1; i_addr = 32'h80;
    nxt(); s_bdone = 1; s_rdata = 32'h55AA55AA; settle();
    checks++;
    if (i_bdone !== 1 || i_berr !== 0 || i_rdata !== 32'h55AA55AA) begin
      errors++; $display("FAIL tmo_after_i: bdone=%b berr=%b rdata=%h expected 1 0 55aa55aa", i_bdone, i_berr, i_rdata);
    end
    nxt(); i_req = 0; s_bdone = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    d_req = 1; d_addr = 32'h500; d_we = 1; d_wdata = 32'h77;
    nxt();
    i_req = 1; i_addr = 32'h600; settle();
    checks++;
    if (s_req !== 1 || s_we !== 1) begin
      errors++; $display("FAIL ar_own_d: s_req=%b s_we=%b expected 1 1", s_req, s_we);
    end
    #1 rst = 1; #1;
    checks++;
    if ({s_req, s_we, i_bdone, d_bdone} !== 4'b0 || s_addr !== '0 || s_wdata !== '0) begin
      errors++; $display("FAIL ar_outputs: s_req=%b s_we=%b s_addr=%h s_wdata=%h expected 0",
                         s_req, s_we, s_addr, s_wdata);
    end
    #1 rst = 0;
    nxt(); settle();
    checks++;
    if (s_req !== 1 || s_addr !== 32'h600 || s_we !== 0) begin
      errors++; $display("FAIL ar_i_first: s_req=%b s_addr=%h s_we=%b expected 1 600 0", s_req, s_addr, s_we);
    end
    i_req = 0; d_req = 0;
  endtask

  task automatic test_done_at_timeout();
    do_reset();
    i_req = 1; i_addr = 32'h44;
    nxt();
    for (int k = 0; k < TIMEOUT - 1; k++) nxt();
    s_bdone = 1; s_rdata = 32'hCAFEF00D; settle();
    checks++;
    if (i_bdone !== 1 || i_berr !== 0 || i_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL late_done: bdone=%b berr=%b rdata=%h expected 1 0 cafef00d", i_bdone, i_berr, i_rdata);
    end
    nxt(); i_req = 0; s_bdone = 0;
  endtask

  initial begin
    test_reset();
    test_ibus_read();
    test_back_to_back();
    test_dbus_write();
    test_timeout();
    test_async_reset();
    test_done_at_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
